// File: rtl/multi_issue_queue_pkg.sv
// Shared constants and entry record for the multi-issue queue.
// Widths here set the storage format of one queue slot.
package multi_issue_queue_pkg;

  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int IQ_DEPTH      = 8;
  localparam int IQ_DISPATCH_W = 2;
  localparam int IQ_ISSUE_W    = 2;
  localparam int IQ_WB_W       = 2;
  localparam int IQ_PAYLOAD_W  = 128;

  typedef struct packed {
    logic                            valid;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] src1_tag;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] src2_tag;
    logic                            src1_rdy;
    logic                            src2_rdy;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] dst_tag;
    logic [IQ_PAYLOAD_W-1:0]         payload;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Age-matrix select: port k is granted the k-th oldest
// eligible entry, ranked by how many eligible entries precede it.
module iq_age_select #(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  input  logic [DEPTH-1:0]            elig,
  output logic [ISSUE_W-1:0][DEPTH-1:0] grant
);

  localparam int RW = $clog2(DEPTH) + 1;

  logic [RW-1:0] r;

  always_comb begin
    grant = '0;
    r     = '0;
    for (int e = 0; e < DEPTH; e++) begin
      r = '0;
      for (int o = 0; o < DEPTH; o++)
        if (o != e)
          r = r + RW'(elig[o] & age[o][e]);
      for (int k = 0; k < ISSUE_W; k++)
        grant[k][e] = elig[e] && (r == RW'(k));
    end
  end

endmodule

// File: rtl/multi_issue_queue.sv
// Out-of-order issue queue: multi-lane dispatch, tag wakeup,
// age-ordered multi-port select.
module multi_issue_queue
  import multi_issue_queue_pkg::*;
#(
  parameter int DEPTH      = IQ_DEPTH,
  parameter int DISPATCH_W = IQ_DISPATCH_W,
  parameter int ISSUE_W    = IQ_ISSUE_W,
  parameter int WB_W       = IQ_WB_W,
  parameter int TAG_W      = PHYS_REGS_ADDR_WIDTH,
  parameter int PAYLOAD_W  = IQ_PAYLOAD_W,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DISPATCH_W-1:0]         disp_valid,
  output logic                          disp_ready,
  input  logic [DISPATCH_W*TAG_W-1:0]   disp_src1_tag,
  input  logic [DISPATCH_W*TAG_W-1:0]   disp_src2_tag,
  input  logic [DISPATCH_W-1:0]         disp_src1_rdy,
  input  logic [DISPATCH_W-1:0]         disp_src2_rdy,
  input  logic [DISPATCH_W*TAG_W-1:0]   disp_dst_tag,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
  input  logic [WB_W-1:0]               wb_valid,
  input  logic [WB_W*TAG_W-1:0]         wb_tag,
  output logic [ISSUE_W-1:0]            iss_valid,
  input  logic [ISSUE_W-1:0]            iss_ready,
  output logic [ISSUE_W*TAG_W-1:0]      iss_dst_tag,
  output logic [ISSUE_W*PAYLOAD_W-1:0]  iss_payload,
  output logic [CNT_W-1:0]              count
);

  localparam int ETW = PHYS_REGS_ADDR_WIDTH;
  localparam int EPW = IQ_PAYLOAD_W;

  iq_entry_t ent_q [DEPTH];
  iq_entry_t ent_d [DEPTH];
  iq_entry_t lane_ent [DISPATCH_W];

  logic [DEPTH-1:0][DEPTH-1:0]      age_q, age_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [CNT_W-1:0]                 nfree, ndisp, niss;
  logic [DEPTH-1:0]                 elig, freed;
  logic [ISSUE_W-1:0][DEPTH-1:0]    grant;
  logic [DISPATCH_W-1:0][DEPTH-1:0] slot;
  logic [DISPATCH_W-1:0]            lane_we;
  logic [ETW-1:0]                   wtag [WB_W];

  assign count      = count_q;
  assign disp_ready = !flush && (count_q <= CNT_W'(DEPTH - DISPATCH_W));
  assign lane_we    = disp_valid & {DISPATCH_W{disp_ready}};

  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      elig[e] = ent_q[e].valid & ent_q[e].src1_rdy & ent_q[e].src2_rdy;
  end

  iq_age_select #(
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_sel (
    .age   (age_q),
    .elig  (elig),
    .grant (grant)
  );

  always_comb begin
    iss_valid   = '0;
    iss_dst_tag = '0;
    iss_payload = '0;
    freed       = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      iss_valid[k] = |grant[k];
      for (int e = 0; e < DEPTH; e++)
        if (grant[k][e]) begin
          iss_dst_tag[k*TAG_W +: TAG_W]         = TAG_W'(ent_q[e].dst_tag);
          iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = PAYLOAD_W'(ent_q[e].payload);
          freed[e] = iss_ready[k];
        end
    end
  end

  // Lane i takes the i-th free slot counting from entry 0.
  always_comb begin
    slot  = '0;
    nfree = '0;
    for (int e = 0; e < DEPTH; e++)
      if (!ent_q[e].valid) begin
        for (int i = 0; i < DISPATCH_W; i++)
          if (nfree == CNT_W'(i))
            slot[i][e] = 1'b1;
        nfree = nfree + CNT_W'(1);
      end
  end

  always_comb begin
    for (int w = 0; w < WB_W; w++)
      wtag[w] = ETW'(wb_tag[w*TAG_W +: TAG_W]);
    for (int i = 0; i < DISPATCH_W; i++) begin
      lane_ent[i]          = '0;
      lane_ent[i].valid    = 1'b1;
      lane_ent[i].src1_tag = ETW'(disp_src1_tag[i*TAG_W +: TAG_W]);
      lane_ent[i].src2_tag = ETW'(disp_src2_tag[i*TAG_W +: TAG_W]);
      lane_ent[i].dst_tag  = ETW'(disp_dst_tag[i*TAG_W +: TAG_W]);
      lane_ent[i].payload  = EPW'(disp_payload[i*PAYLOAD_W +: PAYLOAD_W]);
      lane_ent[i].src1_rdy = disp_src1_rdy[i];
      lane_ent[i].src2_rdy = disp_src2_rdy[i];
      for (int w = 0; w < WB_W; w++)
        if (wb_valid[w]) begin
          if (wtag[w] == lane_ent[i].src1_tag) lane_ent[i].src1_rdy = 1'b1;
          if (wtag[w] == lane_ent[i].src2_tag) lane_ent[i].src2_rdy = 1'b1;
        end
    end
  end

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    ndisp = '0;
    niss  = '0;
    for (int k = 0; k < ISSUE_W; k++)
      if (iss_valid[k] && iss_ready[k])
        niss = niss + CNT_W'(1);
    for (int e = 0; e < DEPTH; e++) begin
      if (freed[e]) ent_d[e].valid = 1'b0;
      for (int w = 0; w < WB_W; w++)
        if (wb_valid[w]) begin
          if (ent_q[e].src1_tag == wtag[w]) ent_d[e].src1_rdy = 1'b1;
          if (ent_q[e].src2_tag == wtag[w]) ent_d[e].src2_rdy = 1'b1;
        end
    end
    // New entries are younger than every surviving resident.
    for (int i = 0; i < DISPATCH_W; i++)
      if (lane_we[i]) begin
        ndisp = ndisp + CNT_W'(1);
        for (int e = 0; e < DEPTH; e++)
          if (slot[i][e]) begin
            ent_d[e] = lane_ent[i];
            for (int b = 0; b < DEPTH; b++) begin
              age_d[e][b] = 1'b0;
              age_d[b][e] = ent_q[b].valid & ~freed[b];
            end
          end
      end
    for (int i = 0; i < DISPATCH_W; i++)
      for (int j = i + 1; j < DISPATCH_W; j++)
        if (lane_we[i] && lane_we[j])
          for (int e = 0; e < DEPTH; e++)
            for (int f = 0; f < DEPTH; f++)
              if (slot[i][e] && slot[j][f])
                age_d[e][f] = 1'b1;
    count_d = count_q + ndisp - niss;
    if (flush) begin
      for (int e = 0; e < DEPTH; e++) ent_d[e].valid = 1'b0;
      age_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
      age_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multi_issue_queue.sv
// Bench for multi_issue_queue: directed scenarios plus a random
// run against an age-ordered queue model.
module tb_multi_issue_queue;

  localparam int D  = 8;
  localparam int DW = 2;
  localparam int IW = 2;
  localparam int WW = 2;
  localparam int TW = 6;
  localparam int PW = 128;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush;
  logic [DW-1:0]    disp_valid, disp_src1_rdy, disp_src2_rdy;
  logic             disp_ready;
  logic [DW*TW-1:0] disp_src1_tag, disp_src2_tag, disp_dst_tag;
  logic [DW*PW-1:0] disp_payload;
  logic [WW-1:0]    wb_valid;
  logic [WW*TW-1:0] wb_tag;
  logic [IW-1:0]    iss_valid, iss_ready;
  logic [IW*TW-1:0] iss_dst_tag;
  logic [IW*PW-1:0] iss_payload;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int dst;
    int s1;
    int s2;
    bit r1;
    bit r2;
    logic [PW-1:0] pl;
  } ment_t;

  ment_t mq[$];

  always #5 clk = ~clk;

  multi_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_dst_tag(iss_dst_tag), .iss_payload(iss_payload),
    .count(count)
  );

  task automatic clear_in();
    flush = 0; disp_valid = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_dst_tag = '0;
    disp_payload = '0; wb_valid = '0; wb_tag = '0; iss_ready = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input int dst, input int s1,
                          input bit r1, input int s2, input bit r2);
    disp_valid[l] = 1'b1;
    disp_dst_tag[l*TW +: TW]  = TW'(dst);
    disp_src1_tag[l*TW +: TW] = TW'(s1);
    disp_src2_tag[l*TW +: TW] = TW'(s2);
    disp_src1_rdy[l] = r1;
    disp_src2_rdy[l] = r2;
    disp_payload[l*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_wb(input int w, input int t);
    wb_valid[w] = 1'b1;
    wb_tag[w*TW +: TW] = TW'(t);
  endtask

  function automatic int pdst(input int k);
    return int'(iss_dst_tag[k*TW +: TW]);
  endfunction

  function automatic bit wb_hit(input int t);
    for (int w = 0; w < WW; w++)
      if (wb_valid[w] && int'(wb_tag[w*TW +: TW]) == t) return 1'b1;
    return 1'b0;
  endfunction

  // Queue order is age order; port k takes the k-th ready entry.
  task automatic model_step();
    int el[$];
    bit acc;
    ment_t m;
    acc = !flush && (D - mq.size() >= DW);
    if (flush) begin
      mq.delete();
      return;
    end
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) el.push_back(i);
    foreach (mq[i]) begin
      if (wb_hit(mq[i].s1)) mq[i].r1 = 1'b1;
      if (wb_hit(mq[i].s2)) mq[i].r2 = 1'b1;
    end
    for (int k = IW - 1; k >= 0; k--)
      if (k < el.size() && iss_ready[k]) mq.delete(el[k]);
    if (acc)
      for (int l = 0; l < DW; l++)
        if (disp_valid[l]) begin
          m.dst = int'(disp_dst_tag[l*TW +: TW]);
          m.s1  = int'(disp_src1_tag[l*TW +: TW]);
          m.s2  = int'(disp_src2_tag[l*TW +: TW]);
          m.r1  = disp_src1_rdy[l] | wb_hit(m.s1);
          m.r2  = disp_src2_rdy[l] | wb_hit(m.s2);
          m.pl  = disp_payload[l*PW +: PW];
          mq.push_back(m);
        end
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    #12;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL reset_iss_valid got %b want 00", iss_valid); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_issue();
    logic [PW-1:0] p0, p1;
    clear_in();
    set_lane(0, 5, 1, 1, 2, 1);
    set_lane(1, 6, 1, 1, 2, 1);
    p0 = disp_payload[0 +: PW];
    p1 = disp_payload[PW +: PW];
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid got %b want 11", iss_valid); end
    n_checks++; if (pdst(0) != 5) begin n_fail++; $display("FAIL basic_dst0 got %0d want 5", pdst(0)); end
    n_checks++; if (pdst(1) != 6) begin n_fail++; $display("FAIL basic_dst1 got %0d want 6", pdst(1)); end
    n_checks++; if (iss_payload !== {p1, p0}) begin n_fail++; $display("FAIL basic_payload got %h want %h", iss_payload, {p1, p0}); end
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL basic_count got %0d want 2", count); end
    iss_ready = 2'b11;
    tick();
    clear_in();
    n_checks++; if (count !== 4'd0 || iss_valid !== 2'b00) begin n_fail++; $display("FAIL basic_drain got count %0d valid %b want 0 00", count, iss_valid); end
  endtask

  task automatic test_wakeup_latency();
    clear_in();
    set_lane(0, 7, 3, 0, 4, 1);
    tick();
    clear_in();
    for (int c = 0; c < 2; c++) begin
      n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL wake_early cyc %0d got %b want 00", c, iss_valid); end
      tick();
    end
    set_wb(1, 3);
    n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL wake_same_cycle got %b want 00", iss_valid); end
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b01 || pdst(0) != 7) begin n_fail++; $display("FAIL wake_issue got %b dst %0d want 01 dst 7", iss_valid, pdst(0)); end
    iss_ready = 2'b01;
    tick();
    clear_in();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL wake_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    for (int c = 0; c < 4; c++) begin
      clear_in();
      set_lane(0, 30 + 2*c, 10 + 2*c, 0, 0, 1);
      set_lane(1, 31 + 2*c, 11 + 2*c, 0, 0, 1);
      tick();
    end
    clear_in();
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", count); end
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", disp_ready); end
    n_checks++; if (iss_valid !== 2'b00) begin n_fail++; $display("FAIL full_nothing_eligible got %b want 00", iss_valid); end
    set_wb(0, 10);
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b01 || pdst(0) != 30) begin n_fail++; $display("FAIL full_wake got %b dst %0d want 01 dst 30", iss_valid, pdst(0)); end
    iss_ready = 2'b01;
    tick();
    clear_in();
    n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_count7 got %0d want 7", count); end
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready7 got %b want 0", disp_ready); end
    set_wb(0, 11);
    tick();
    clear_in();
    iss_ready = 2'b01;
    tick();
    clear_in();
    n_checks++; if (count !== 4'd6 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_count6 got %0d rdy %b want 6 1", count, disp_ready); end
    flush = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic test_partial_ready();
    clear_in();
    set_lane(0, 20, 1, 1, 1, 1);
    set_lane(1, 21, 1, 1, 1, 1);
    tick();
    clear_in();
    set_lane(0, 22, 1, 1, 1, 1);
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b11 || pdst(0) != 20 || pdst(1) != 21) begin n_fail++; $display("FAIL age_first got %b %0d %0d want 11 20 21", iss_valid, pdst(0), pdst(1)); end
    iss_ready = 2'b01;
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b11 || pdst(0) != 21 || pdst(1) != 22) begin n_fail++; $display("FAIL age_shift got %b %0d %0d want 11 21 22", iss_valid, pdst(0), pdst(1)); end
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL age_count got %0d want 2", count); end
    iss_ready = 2'b10;
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b01 || pdst(0) != 21) begin n_fail++; $display("FAIL age_port1_only got %b %0d want 01 21", iss_valid, pdst(0)); end
    iss_ready = 2'b01;
    tick();
    clear_in();
  endtask

  task automatic test_bypass();
    clear_in();
    set_lane(0, 40, 9, 0, 9, 0);
    set_wb(1, 9);
    tick();
    clear_in();
    n_checks++; if (iss_valid !== 2'b01 || pdst(0) != 40) begin n_fail++; $display("FAIL bypass got %b dst %0d want 01 dst 40", iss_valid, pdst(0)); end
    iss_ready = 2'b01;
    tick();
    clear_in();
  endtask

  task automatic test_flush_and_reset();
    for (int c = 0; c < 3; c++) begin
      clear_in();
      set_lane(0, 50 + c, 60, 0, 0, 1);
      if (c < 2) set_lane(1, 55 + c, 60, 0, 0, 1);
      tick();
    end
    clear_in();
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre got %0d want 5", count); end
    flush = 1'b1;
    set_lane(0, 1, 1, 1, 1, 1);
    set_wb(0, 60);
    #1;
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", disp_ready); end
    tick();
    clear_in();
    n_checks++; if (count !== 4'd0 || iss_valid !== 2'b00) begin n_fail++; $display("FAIL flush_post got %0d %b want 0 00", count, iss_valid); end
    set_lane(0, 11, 1, 1, 1, 1);
    set_lane(1, 12, 1, 1, 1, 1);
    tick();
    clear_in();
    iss_ready = 2'b11;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 4'd0 || iss_valid !== 2'b00 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst got %0d %b %b want 0 00 1", count, iss_valid, disp_ready); end
    #1;
    rst = 1'b0;
    clear_in();
    tick();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_no_issue got %0d want 0", count); end
  endtask

  task automatic test_random();
    int el[$];
    bit er;
    clear_in();
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      clear_in();
      flush = ($urandom_range(0, 39) == 0);
      for (int l = 0; l < DW; l++)
        if ($urandom_range(0, 1) == 1)
          set_lane(l, $urandom_range(0, 63), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      for (int w = 0; w < WW; w++)
        if ($urandom_range(0, 2) != 0) set_wb(w, $urandom_range(0, 7));
      iss_ready = IW'($urandom);
      #1;
      el.delete();
      foreach (mq[i]) if (mq[i].r1 && mq[i].r2) el.push_back(i);
      er = !flush && (D - mq.size() >= DW);
      n_checks++; if (int'(count) != mq.size()) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, mq.size()); end
      n_checks++; if (disp_ready !== er) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, disp_ready, er); end
      for (int k = 0; k < IW; k++) begin
        n_checks++; if (iss_valid[k] !== (k < el.size())) begin n_fail++; $display("FAIL rnd_valid cyc %0d port %0d got %b", c, k, iss_valid[k]); end
        if (k < el.size()) begin
          n_checks++; if (pdst(k) != mq[el[k]].dst) begin n_fail++; $display("FAIL rnd_dst cyc %0d port %0d got %0d want %0d", c, k, pdst(k), mq[el[k]].dst); end
          n_checks++; if (iss_payload[k*PW +: PW] !== mq[el[k]].pl) begin n_fail++; $display("FAIL rnd_payload cyc %0d port %0d got %h want %h", c, k, iss_payload[k*PW +: PW], mq[el[k]].pl); end
        end
      end
      model_step();
      tick();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_basic_issue();
    test_wakeup_latency();
    test_full();
    test_partial_ready();
    test_bypass();
    test_flush_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
